// File: rtl/jstepper_ctl.sv
// Instruction-cycle sequencer: one-hot step ring plus 4-phase clke/clks generation,
// run/halt at instruction boundaries and early end-of-instruction.
module jstepper_ctl #(
  parameter int unsigned NSTEPS = 6
) (
  input  logic              wclk,
  input  logic              wreset,
  input  logic              wrun,
  input  logic              wend,
  output logic [NSTEPS-1:0] bsteps,
  output logic              wclke,
  output logic              wclks,
  output logic              wbit1,
  output logic              wdone,
  output logic              wbusy
);

  typedef enum logic {StHalted, StRun} state_e;

  localparam logic [NSTEPS-1:0] RingFirst = {{(NSTEPS-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [1:0]        phase_q;
  logic [NSTEPS-1:0] ring_q;

  logic running;
  logic last_phase;
  logic instr_end;

  assign running    = (state_q == StRun);
  assign last_phase = (phase_q == 2'd3);
  // The ring stays one-hot at all times; it is masked off while halted.
  assign instr_end  = running && last_phase && (ring_q[NSTEPS-1] || wend);

  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      state_q <= StHalted;
      phase_q <= 2'd0;
      ring_q  <= RingFirst;
    end else begin
      unique case (state_q)
        StHalted: begin
          phase_q <= 2'd0;
          ring_q  <= RingFirst;
          if (wrun) state_q <= StRun;
        end
        StRun: begin
          if (!last_phase) begin
            phase_q <= phase_q + 2'd1;
          end else if (instr_end) begin
            phase_q <= 2'd0;
            ring_q  <= RingFirst;
            state_q <= wrun ? StRun : StHalted;
          end else begin
            phase_q <= 2'd0;
            ring_q  <= {ring_q[NSTEPS-2:0], ring_q[NSTEPS-1]};
          end
        end
        default: begin
          state_q <= StHalted;
          phase_q <= 2'd0;
          ring_q  <= RingFirst;
        end
      endcase
    end
  end

  // clks sits in phase 1, strictly inside the phase 0..2 clke window.
  assign bsteps = running ? ring_q : '0;
  assign wclke  = running && !last_phase;
  assign wclks  = running && (phase_q == 2'd1);
  assign wbit1  = running && ring_q[0];
  assign wdone  = instr_end;
  assign wbusy  = running;

endmodule

// File: tb/tb_jstepper_ctl.sv
// Directed bench for jstepper_ctl: NSTEPS=6 instance for the main sequences and an
// NSTEPS=2 instance for the short-instruction case.
module tb_jstepper_ctl;

  logic       clk;
  logic       rst;
  logic       run6, end6, run2, end2;
  logic [5:0] bsteps6;
  logic [1:0] bsteps2;
  logic       clke6, clks6, bit16, done6, busy6;
  logic       clke2, clks2, bit12, done2, busy2;
  logic [20:0] act6, act2;

  int n_cmp;
  int n_bad;

  jstepper_ctl #(.NSTEPS(6)) dut6 (
    .wclk  (clk),
    .wreset(rst),
    .wrun  (run6),
    .wend  (end6),
    .bsteps(bsteps6),
    .wclke (clke6),
    .wclks (clks6),
    .wbit1 (bit16),
    .wdone (done6),
    .wbusy (busy6)
  );

  jstepper_ctl #(.NSTEPS(2)) dut2 (
    .wclk  (clk),
    .wreset(rst),
    .wrun  (run2),
    .wend  (end2),
    .bsteps(bsteps2),
    .wclke (clke2),
    .wclks (clks2),
    .wbit1 (bit12),
    .wdone (done2),
    .wbusy (busy2)
  );

  assign act6 = {10'b0, bsteps6, clke6, clks6, bit16, done6, busy6};
  assign act2 = {14'b0, bsteps2, clke2, clks2, bit12, done2, busy2};

  always #5 clk = ~clk;

  // {one-hot step[15:0], clke, clks, bit1, done, busy}; step < 0 means halted.
  function automatic logic [20:0] expv(input int step, input int ph, input logic done);
    logic [15:0] s;
    if (step < 0) return '0;
    s = 16'd1 << step;
    return {s, (ph != 3), (ph == 1), (step == 0), done, 1'b1};
  endfunction

  task automatic check_eq(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle, drive inputs for it, then check the cycle's outputs.
  task automatic cyc(input bit sel2, input logic run, input logic e, input int step,
                     input int ph, input logic done, input string tag);
    @(posedge clk);
    #1;
    if (sel2) run2 = run;
    else begin
      run6 = run;
      end6 = e;
    end
    #1;
    check_eq(tag, sel2 ? act2 : act6, expv(step, ph, done));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    run6  = 1'b0;
    end6  = 1'b0;
    run2  = 1'b0;
    end2  = 1'b0;
    #12 rst = 1'b0;
    #1;
    check_eq("reset6", act6, '0);
    check_eq("reset2", act2, '0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, -1, 0, 0, "idle");

    // Full 6-step instruction, wrun held high
    cyc(0, 1, 0, -1, 0, 0, "start");
    for (int c = 1; c <= 25; c++)
      cyc(0, 1, 0, ((c - 1) / 4) % 6, (c - 1) % 4, (c == 24), "full");

    // Early end in step 2; wend in phases 0-2 must be ignored
    for (int r = 1; r <= 11; r++)
      cyc(0, 1, ((r % 4) != 3) || (r / 4 == 2), r / 4, r % 4, (r == 11), "early");
    cyc(0, 1, 0, 0, 0, 0, "early_next");

    // Drop wrun in step 3: instruction completes, then halt
    for (int r = 1; r <= 23; r++)
      cyc(0, (r < 12), 0, r / 4, r % 4, (r == 23), "halt_run");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, -1, 0, 0, "halted");
    cyc(0, 1, 0, -1, 0, 0, "rerun");
    cyc(0, 1, 0, 0, 0, 0, "rerun_s0");

    // wrun glitch from step 1 to step 4: no halt
    for (int r = 1; r <= 23; r++)
      cyc(0, !(r >= 4 && r < 16), 0, r / 4, r % 4, (r == 23), "glitch");
    for (int r = 0; r <= 13; r++)
      cyc(0, 1, 0, r / 4, r % 4, 0, "glitch_next");

    // Asynchronous reset in step 3, phase 1
    rst = 1'b1;
    #1;
    check_eq("rst_async", act6, '0);
    run6 = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("rst_release", act6, '0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, -1, 0, 0, "post_rst");

    // NSTEPS=2: 8-cycle instructions
    cyc(1, 1, 0, -1, 0, 0, "n2_start");
    for (int r = 0; r < 17; r++)
      cyc(1, 1, 0, (r / 4) % 2, r % 4, (r % 8 == 7), "n2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
